// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter slice: default widths,
// fetch starvation limit and the arbiter FSM state encoding.
package cpu_pkg;

    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 4;

    // Arbiter FSM: which port, if any, has an access in flight
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_PEND = 2'd1;
    localparam logic [1:0] ST_DM_PEND = 2'd2;

    // The state after any cycle depends only on which grant fired in it
    function automatic logic [1:0] next_state(input logic if_gnt, input logic dm_gnt);
        if (if_gnt) begin
            return ST_IF_PEND;
        end
        if (dm_gnt) begin
            return ST_DM_PEND;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles the fetch port has waited.
// 'expired' tells the arbiter that fetch must now win over data.
module starve_counter #(
    parameter int LIMIT = cpu_pkg::STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic expired
);

    localparam logic [2:0] LIMIT_C = 3'(LIMIT);

    logic [2:0] cnt;

    // Count waiting cycles, saturate at the limit, clear once served or withdrawn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt < LIMIT_C) begin
            cnt <= cnt + 3'd1;
        end
    end

    assign expired = (cnt >= LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous
// memory. One access per cycle, data preferred unless fetch has starved.
module mem_arbiter #(
    parameter int ADDR_W       = cpu_pkg::ADDR_W,
    parameter int DATA_W       = cpu_pkg::DATA_W,
    parameter int STARVE_LIMIT = cpu_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import cpu_pkg::*;

    logic [1:0]        state;
    logic              pend_we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fetch_starved;
    logic              grant_ok;

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .req    (if_req),
        .gnt    (if_gnt),
        .expired(fetch_starved)
    );

    // Pick at most one winner; grants are forced low during reset and halt
    always_comb begin
        grant_ok = rst & ~halt;
        if_gnt   = grant_ok & if_req & (~dm_req | fetch_starved);
        dm_gnt   = grant_ok & dm_req & ~(if_req & fetch_starved);
    end

    // Drive the memory port from the winner, otherwise hold the last address/data
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (if_gnt) begin
            mem_addr  = if_addr;
            mem_wdata = '0;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    // Track the in-flight access and remember the last memory address/data driven
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            pend_we <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= next_state(if_gnt, dm_gnt);
            pend_we <= dm_gnt & dm_we;
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
        end
    end

    // Return read data to the port whose access completes this cycle
    always_comb begin
        if_valid = (state == ST_IF_PEND);
        dm_valid = (state == ST_DM_PEND);
        if_rdata = '0;
        dm_rdata = '0;
        if (if_valid) begin
            if_rdata = mem_rdata;
        end
        if (dm_valid && !pend_we) begin
            dm_rdata = mem_rdata;
        end
    end

endmodule
